debug_unit_ctrl: RTL and testbench

Command sequencer between the UART and the MIPS pipeline on the board top level. It decodes single-byte host commands, loads instruction memory byte-by-byte, and gates the pipeline clock enable in continuous or step-by-step mode. After each step or halt it streams the pipeline state (PC and, optionally, the cycle count) back through the UART transmitter.

---
 rtl/debug_unit_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_debug_unit_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit_ctrl.sv
// Host command sequencer: imem byte loader, pipeline run/step gating, PC dump over UART.
// Define DEBUG_CYCLE_COUNT_EN to add the enabled-cycle counter to each dump.
module debug_unit_ctrl #(
  parameter int unsigned    LEN         = 32,
  parameter int unsigned    IMEM_ADDR_W = 10,
  parameter logic [LEN-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                   CLK100MHZ,
  input  logic                   SWITCH_RESET,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_done_tick_i,
  input  logic                   tx_done_tick_i,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  input  logic [LEN-1:0]         pc_i,
  input  logic                   halt_i,
  output logic                   pipe_en_o,
  output logic                   pipe_rst_o,
  output logic                   imem_we_o,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  output logic [LEN-1:0]         imem_data_o
);

  localparam logic [7:0] CmdStart   = 8'h01;
  localparam logic [7:0] CmdCont    = 8'h02;
  localparam logic [7:0] CmdStepBy  = 8'h03;
  localparam logic [7:0] CmdReprog  = 8'h05;
  localparam logic [7:0] CmdStep    = 8'h06;

  localparam int unsigned NumBytes = LEN / 8;
  localparam int unsigned BW       = (NumBytes > 1) ? $clog2(NumBytes) : 1;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int unsigned DumpBytes = 2 * NumBytes;
`else
  localparam int unsigned DumpBytes = NumBytes;
`endif
  localparam int unsigned DW = $clog2(DumpBytes);

  typedef enum logic [2:0] {
    StIdle, StProgram, StRun, StStepWait, StStepExec, StSend
  } state_e;

  state_e                  state_q, state_d;
  logic                    ret_step_q, ret_step_d;
  logic                    send_first_q, send_first_d;
  logic [BW-1:0]           byte_idx_q, byte_idx_d;
  logic [LEN-1:0]          word_q, word_d;
  logic [DumpBytes*8-1:0]  dump_q, dump_d;
  logic [DW-1:0]           dump_cnt_q, dump_cnt_d;
  logic                    tx_start_q, tx_start_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    pipe_rst_q, pipe_rst_d;
  logic                    imem_we_q, imem_we_d;
  logic [IMEM_ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [LEN-1:0]          imem_data_q, imem_data_d;
  logic [LEN-1:0]          word_asm;
  logic [DumpBytes*8-1:0]  dump_load;

  // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
  assign word_asm = {rx_data_i, word_q[LEN-1:8]};

  // Combinational so the pipeline stops in the very cycle halt_i rises.
  assign pipe_en_o = ((state_q == StRun) && !halt_i) || (state_q == StStepExec);

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [LEN-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && rx_done_tick_i && rx_data_i == CmdStart) begin
      cnt_d = '0;
    end else if (pipe_en_o) begin
      cnt_d = cnt_q + LEN'(1);
    end
  end

  always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
    if (SWITCH_RESET) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign dump_load = {cnt_q, pc_i};
`else
  assign dump_load = pc_i;
`endif

  always_comb begin
    state_d      = state_q;
    ret_step_d   = ret_step_q;
    send_first_d = send_first_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    dump_d       = dump_q;
    dump_cnt_d   = dump_cnt_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    pipe_rst_d   = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;

    if (imem_we_q) imem_addr_d = imem_addr_q + IMEM_ADDR_W'(1);

    case (state_q)
      StIdle: begin
        if (rx_done_tick_i) begin
          case (rx_data_i)
            CmdStart:  pipe_rst_d = 1'b1;
            CmdReprog: begin
              state_d     = StProgram;
              imem_addr_d = '0;
              byte_idx_d  = '0;
            end
            CmdCont:   state_d = StRun;
            CmdStepBy: state_d = StStepWait;
            default:   ;
          endcase
        end
      end
      StProgram: begin
        if (rx_done_tick_i) begin
          word_d = word_asm;
          if (byte_idx_q == BW'(NumBytes - 1)) begin
            byte_idx_d  = '0;
            imem_we_d   = 1'b1;
            imem_data_d = word_asm;
            if (word_asm == HALT_WORD) state_d = StIdle;
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
          end
        end
      end
      StRun: begin
        if (halt_i) begin
          state_d      = StSend;
          send_first_d = 1'b1;
          ret_step_d   = 1'b0;
        end
      end
      StStepWait: begin
        if (rx_done_tick_i) begin
          if (rx_data_i == CmdStep && !halt_i) state_d = StStepExec;
          else if (rx_data_i == CmdCont)       state_d = StRun;
        end
      end
      StStepExec: begin
        state_d      = StSend;
        send_first_d = 1'b1;
        ret_step_d   = 1'b1;
      end
      StSend: begin
        if (send_first_q) begin
          // PC is sampled here, after the stepped pipeline has updated it.
          send_first_d = 1'b0;
          dump_d       = dump_load;
          dump_cnt_d   = '0;
          tx_start_d   = 1'b1;
          tx_data_d    = dump_load[7:0];
        end else if (tx_done_tick_i) begin
          if (dump_cnt_q == DW'(DumpBytes - 1)) begin
            state_d = (ret_step_q && !halt_i) ? StStepWait : StIdle;
          end else begin
            dump_cnt_d = dump_cnt_q + DW'(1);
            dump_d     = dump_q >> 8;
            tx_start_d = 1'b1;
            tx_data_d  = dump_q[15:8];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
    if (SWITCH_RESET) begin
      state_q      <= StIdle;
      ret_step_q   <= 1'b0;
      send_first_q <= 1'b0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      dump_q       <= '0;
      dump_cnt_q   <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      pipe_rst_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ret_step_q   <= ret_step_d;
      send_first_q <= send_first_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      dump_q       <= dump_d;
      dump_cnt_q   <= dump_cnt_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      pipe_rst_q   <= pipe_rst_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
    end
  end

  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign pipe_rst_o  = pipe_rst_q;
  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_data_o = imem_data_q;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Scoreboard bench for debug_unit_ctrl: expected UART bytes and imem writes are queued
// by the stimulus and checked by an independent monitor.
module tb_debug_unit_ctrl;
  localparam int unsigned LEN = 32;
  localparam int unsigned AW  = 10;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int DumpBytes = 8;
`else
  localparam int DumpBytes = 4;
`endif

  logic            clk;
  logic            rst;
  logic [7:0]      rx_data_i;
  logic            rx_done_tick_i;
  logic            tx_done_tick_i;
  logic            tx_start_o;
  logic [7:0]      tx_data_o;
  logic [LEN-1:0]  pc_i;
  logic            halt_i;
  logic            pipe_en_o;
  logic            pipe_rst_o;
  logic            imem_we_o;
  logic [AW-1:0]   imem_addr_o;
  logic [LEN-1:0]  imem_data_o;

  debug_unit_ctrl dut (
    .CLK100MHZ      (clk),
    .SWITCH_RESET   (rst),
    .rx_data_i      (rx_data_i),
    .rx_done_tick_i (rx_done_tick_i),
    .tx_done_tick_i (tx_done_tick_i),
    .tx_start_o     (tx_start_o),
    .tx_data_o      (tx_data_o),
    .pc_i           (pc_i),
    .halt_i         (halt_i),
    .pipe_en_o      (pipe_en_o),
    .pipe_rst_o     (pipe_rst_o),
    .imem_we_o      (imem_we_o),
    .imem_addr_o    (imem_addr_o),
    .imem_data_o    (imem_data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int n_en  = 0;
  int n_rst = 0;
  int tx_delay = 3;
  bit tx_busy = 1'b0;
  logic [7:0]        exp_tx[$];
  logic [AW+LEN-1:0] exp_we[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_dump(input logic [63:0] v);
    for (int i = 0; i < DumpBytes; i++) exp_tx.push_back(v[8*i +: 8]);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data_i      = b;
    rx_done_tick_i = 1'b1;
    @(negedge clk);
    rx_done_tick_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_dump(input string name);
    int k;
    k = 0;
    while ((exp_tx.size() != 0 || tx_busy) && k < 20000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_dump_done"}, 64'(k < 20000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_tx_start"}, 64'(tx_start_o), 64'd0);
    chk({name, "_tx_data"},  64'(tx_data_o),  64'd0);
    chk({name, "_pipe_en"},  64'(pipe_en_o),  64'd0);
    chk({name, "_pipe_rst"}, 64'(pipe_rst_o), 64'd0);
    chk({name, "_imem_we"},  64'(imem_we_o),  64'd0);
    chk({name, "_imem_addr"}, 64'(imem_addr_o), 64'd0);
    chk({name, "_imem_data"}, 64'(imem_data_o), 64'd0);
  endtask

  // Monitor: scoreboard pops, pipeline-enable bookkeeping and the PC stub.
  initial begin
    pc_i = 32'h0040_0000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_start_o) begin
          if (exp_tx.size() == 0) chk("tx_unexpected", 64'd1, 64'd0);
          else chk("tx_byte", 64'(tx_data_o), 64'(exp_tx.pop_front()));
        end
        if (imem_we_o) begin
          if (exp_we.size() == 0) chk("we_unexpected", 64'd1, 64'd0);
          else chk("imem_wr", 64'({imem_addr_o, imem_data_o}), 64'(exp_we.pop_front()));
        end
        if (pipe_en_o) begin
          n_en++;
          pc_i = pc_i + 32'd4;
        end
        if (pipe_rst_o) n_rst++;
      end
    end
  end

  // UART transmitter model; also checks that the byte is held while transmitting.
  initial begin
    logic [7:0] d;
    bit bad;
    tx_done_tick_i = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_tick_i = 1'b0;
      tx_busy        = 1'b0;
      if (tx_start_o && !rst) begin
        tx_busy = 1'b1;
        d       = tx_data_o;
        bad     = 1'b0;
        repeat (tx_delay) begin
          @(negedge clk);
          if (tx_start_o || tx_data_o !== d) bad = 1'b1;
        end
        chk("tx_hold", 64'(bad), 64'd0);
        tx_done_tick_i = 1'b1;
      end
    end
  end

  logic [31:0] step_pc [3];

  initial begin
    int e0;
    int r0;
    int k;
    step_pc[0] = 32'h0040_0054;
    step_pc[1] = 32'h0040_0058;
    step_pc[2] = 32'h0040_005C;
    rst = 1'b1;
    rx_data_i = 8'h00;
    rx_done_tick_i = 1'b0;
    halt_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("post_reset");

    // Program load: one data word, then the halt word.
    exp_we.push_back({10'd0, 32'h1234_5678});
    exp_we.push_back({10'd1, 32'hFFFF_FFFF});
    send(8'h05);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    repeat (3) @(negedge clk);
    chk("prog_writes_left", 64'(exp_we.size()), 64'd0);
    chk("prog_next_addr", 64'(imem_addr_o), 64'd2);

    // Unlisted bytes in IDLE.
    e0 = n_en;
    r0 = n_rst;
    send(8'h07);
    send(8'hAA);
    repeat (5) @(negedge clk);
    chk("idle_ignore_en", 64'(n_en), 64'(e0));
    chk("idle_ignore_rst", 64'(n_rst), 64'(r0));

    // Continuous run, halt after 20 enabled cycles.
    e0 = n_en;
    push_dump({32'h0000_0014, 32'h0040_0050});
    send(8'h02);
    k = 0;
    while (n_en - e0 < 20 && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("run_reach_20", 64'(k < 1000), 64'd1);
    halt_i = 1'b1;
    wait_dump("run");
    chk("run_en_cycles", 64'(n_en - e0), 64'd20);
    halt_i = 1'b0;

    // Start pulse clears the counter; then step-by-step.
    r0 = n_rst;
    send(8'h01);
    repeat (2) @(negedge clk);
    chk("start_rst_pulse", 64'(n_rst - r0), 64'd1);
    send(8'h03);
    e0 = n_en;
    send(8'h07);
    send(8'hAA);
    repeat (5) @(negedge clk);
    chk("stepwait_ignore_en", 64'(n_en), 64'(e0));
    for (int i = 0; i < 3; i++) begin
      push_dump({32'(i + 1), step_pc[i]});
      if (i == 1) tx_delay = 1000;
      e0 = n_en;
      send(8'h06);
      if (i == 1) begin
        k = 0;
        while (!tx_busy && k < 100) begin
          @(posedge clk);
          #1;
          k++;
        end
        repeat (5) @(posedge clk);
        tx_delay = 3;
      end
      wait_dump("step");
      chk("step_en_cycles", 64'(n_en - e0), 64'd1);
    end

    // Asynchronous reset while running, then during a partial program word.
    send(8'h02);
    repeat (5) @(negedge clk);
    chk("run2_en", 64'(pipe_en_o), 64'd1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("rst_run");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(8'h05);
    send(8'hAA);
    send(8'hBB);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("rst_prog");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_we.push_back({10'd0, 32'h4433_2211});
    exp_we.push_back({10'd1, 32'hFFFF_FFFF});
    send(8'h05);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    repeat (3) @(negedge clk);
    chk("reprog_writes_left", 64'(exp_we.size()), 64'd0);
    chk("tx_left", 64'(exp_tx.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
